// File: rtl/cluster_vec_sequencer.sv
// Load/settle/capture sequencer for one learned-logic cluster: streams words into vec_o,
// waits SETTLE_CYC edges, then captures bits_i. Define CLUSTER_VEC_SEQ_STEP_EN for feedback stepping.
module cluster_vec_sequencer #(
   parameter int IN_W       = 1894,
   parameter int OUT_W      = 96,
   parameter int WORD_W     = 32,
   parameter int SETTLE_CYC = 2,
   parameter int FB_LSB     = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ld_valid,
   output logic              ld_ready,
   input  logic [WORD_W-1:0] ld_data,
   input  logic              ld_last,
   output logic [IN_W-1:0]   vec_o,
   input  logic [OUT_W-1:0]  bits_i,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [OUT_W-1:0]  res_data,
   output logic              err_len,
`ifdef CLUSTER_VEC_SEQ_STEP_EN
   input  logic              step_i,
`endif
   output logic              busy
);

   localparam int NWORDS = (IN_W + WORD_W - 1) / WORD_W;
   localparam int IDX_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
   localparam int CNT_W  = $clog2(SETTLE_CYC + 1);
   localparam int PAD_W  = NWORDS * WORD_W;

   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NWORDS - 1);
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(SETTLE_CYC);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   if ((SETTLE_CYC < 1) || (FB_LSB + OUT_W > IN_W)) begin : g_bad_cfg
      $error("cluster_vec_sequencer: SETTLE_CYC must be >=1 and the feedback field must fit in IN_W");
   end

   typedef enum logic [1:0] {
      S_LOAD   = 2'd0,
      S_SETTLE = 2'd1,
      S_HOLD   = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [IN_W-1:0]    vec_q, vec_d;
   logic [OUT_W-1:0]   res_data_q, res_data_d;
   logic               res_valid_q, res_valid_d;
   logic               err_len_q, err_len_d;
   logic [PAD_W-1:0]   vec_pad;
   logic               accept;
   logic               res_hs;
   logic               step_go;

`ifdef CLUSTER_VEC_SEQ_STEP_EN
   assign step_go = step_i;
`else
   assign step_go = 1'b0;
`endif

   assign accept = ld_valid && (state_q == S_LOAD);
   assign res_hs = res_valid_q && res_ready;

   // State register (all flops)
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= S_LOAD;
         idx_q       <= '0;
         cnt_q       <= '0;
         vec_q       <= '0;
         res_data_q  <= '0;
         res_valid_q <= 1'b0;
         err_len_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         cnt_q       <= cnt_d;
         vec_q       <= vec_d;
         res_data_q  <= res_data_d;
         res_valid_q <= res_valid_d;
         err_len_q   <= err_len_d;
      end
   end

   // Next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_LOAD:   if (accept && (idx_q == IDX_LAST)) state_d = S_SETTLE;
         S_SETTLE: if (cnt_q == CNT_ONE) state_d = S_HOLD;
         S_HOLD:   if (res_hs) state_d = step_go ? S_SETTLE : S_LOAD;
         default:  state_d = S_LOAD;
      endcase
   end

   // Datapath next values
   always_comb begin
      idx_d       = idx_q;
      cnt_d       = cnt_q;
      vec_d       = vec_q;
      res_data_d  = res_data_q;
      res_valid_d = res_valid_q;
      err_len_d   = 1'b0;
      vec_pad     = '0;
      vec_pad[IN_W-1:0] = vec_q;
      case (state_q)
         S_LOAD: begin
            if (accept) begin
               // Padded copy lets the final word spill past IN_W and be dropped.
               vec_pad[int'(idx_q) * WORD_W +: WORD_W] = ld_data;
               vec_d = vec_pad[IN_W-1:0];
               if (idx_q == IDX_LAST) begin
                  idx_d     = '0;
                  cnt_d     = CNT_INIT;
                  err_len_d = !ld_last;
               end else begin
                  idx_d     = ld_last ? '0 : idx_q + IDX_W'(1);
                  err_len_d = ld_last;
               end
            end
         end
         S_SETTLE: begin
            cnt_d = cnt_q - CNT_ONE;
            if (cnt_q == CNT_ONE) begin
               res_data_d  = bits_i;
               res_valid_d = 1'b1;
            end
         end
         S_HOLD: begin
            if (res_hs) begin
               res_valid_d = 1'b0;
               if (step_go) begin
                  vec_d[FB_LSB +: OUT_W] = res_data_q;
                  cnt_d = CNT_INIT;
               end
            end
         end
         default: ;
      endcase
   end

   // Outputs
   always_comb begin
      ld_ready  = (state_q == S_LOAD);
      busy      = (state_q == S_SETTLE) || (state_q == S_HOLD);
      vec_o     = vec_q;
      res_valid = res_valid_q;
      res_data  = res_data_q;
      err_len   = err_len_q;
   end

endmodule

// File: tb/tb_cluster_vec_sequencer.sv
// Directed bench for cluster_vec_sequencer; a cluster stand-in drives bits_i from vec_o.
module tb_cluster_vec_sequencer;

   localparam int IN_W   = 1894;
   localparam int OUT_W  = 96;
   localparam int WORD_W = 32;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              ld_valid;
   logic              ld_ready;
   logic [WORD_W-1:0] ld_data;
   logic              ld_last;
   logic [IN_W-1:0]   vec_o;
   logic [OUT_W-1:0]  bits_i;
   logic              res_valid;
   logic              res_ready;
   logic [OUT_W-1:0]  res_data;
   logic              err_len;
   logic              busy;
   logic              inv;
`ifdef CLUSTER_VEC_SEQ_STEP_EN
   logic              step_i;
`endif

   int n_chk  = 0;
   int n_pass = 0;

   logic [IN_W-1:0]  snap_vec;
   logic [OUT_W-1:0] snap_res;
   logic [OUT_W-1:0] r1;
   logic             err_seen;
   logic             bp_bad;
   int               err_cnt;

   always #5 clk = ~clk;

   // Cluster stand-in: identity with bit0 flipped, or full inversion for stepping
   assign bits_i = inv ? ~vec_o[OUT_W-1:0] : (vec_o[OUT_W-1:0] ^ 96'h1);

   cluster_vec_sequencer dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .ld_valid  (ld_valid),
      .ld_ready  (ld_ready),
      .ld_data   (ld_data),
      .ld_last   (ld_last),
      .vec_o     (vec_o),
      .bits_i    (bits_i),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_data  (res_data),
      .err_len   (err_len),
`ifdef CLUSTER_VEC_SEQ_STEP_EN
      .step_i    (step_i),
`endif
      .busy      (busy)
   );

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: got %b want %b", tag, obs, exp);
   endtask

   task automatic chkw(input string tag, input logic [OUT_W-1:0] obs, input logic [OUT_W-1:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: got %h want %h", tag, obs, exp);
   endtask

   task automatic send(input logic [WORD_W-1:0] d, input logic last);
      ld_valid = 1'b1;
      ld_data  = d;
      ld_last  = last;
      cyc();
      ld_valid = 1'b0;
      ld_last  = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; ld_valid = 1'b1; ld_data = '1; ld_last = 1'b0;
      res_ready = 1'b0; inv = 1'b0;
`ifdef CLUSTER_VEC_SEQ_STEP_EN
      step_i = 1'b0;
`endif
      // Reset with a word offered the whole time
      repeat (3) cyc();
      rst_n = 1'b1; ld_valid = 1'b0;
      chk1("rst_vec_zero", vec_o == '0, 1'b1);
      chk1("rst_res_valid", res_valid, 1'b0);
      chk1("rst_ld_ready", ld_ready, 1'b1);
      chk1("rst_busy", busy, 1'b0);
      chk1("rst_err_len", err_len, 1'b0);
      chkw("rst_res_data", res_data, '0);

      // Full frame: word k = k
      err_seen = 1'b0;
      for (int k = 0; k < 60; k++) begin
         send(WORD_W'(k), k == 59);
         err_seen |= err_len;
      end
      chk1("f1_no_err", err_seen, 1'b0);
      chk1("f1_busy", busy, 1'b1);
      chk1("f1_ld_ready", ld_ready, 1'b0);
      chk1("f1_valid_e0", res_valid, 1'b0);
      chk1("f1_tail_trunc", vec_o[IN_W-1:1888] == 6'h3B, 1'b1);
      cyc();
      chk1("f1_valid_e1", res_valid, 1'b0);
      cyc();
      chk1("f1_valid_e2", res_valid, 1'b1);
      // words 2,1,0 = 2,1,0 with bit0 flipped
      chkw("f1_res_data", res_data, {32'h2, 32'h1, 32'h1});

      // Backpressure with loads offered
      snap_vec = vec_o; snap_res = res_data; bp_bad = 1'b0;
      ld_valid = 1'b1; ld_data = 32'hDEADBEEF; ld_last = 1'b1;
      repeat (10) begin
         cyc();
         if (vec_o !== snap_vec || res_data !== snap_res || ld_ready !== 1'b0 || res_valid !== 1'b1)
            bp_bad = 1'b1;
      end
      chk1("bp_stable", bp_bad, 1'b0);
      res_ready = 1'b1;
      cyc();
      chk1("bp_valid_drop", res_valid, 1'b0);
      chk1("bp_ld_ready_after", ld_ready, 1'b1);
      chk1("bp_busy_clear", busy, 1'b0);
      chk1("bp_no_bypass", vec_o == snap_vec, 1'b1);
      res_ready = 1'b0; ld_valid = 1'b0; ld_last = 1'b0;

      // Early last on word 5
      for (int k = 0; k < 6; k++) send(32'hA0 + WORD_W'(k), k == 5);
      chk1("early_err_pulse", err_len, 1'b1);
      chk1("early_stay_load", ld_ready, 1'b1);
      chk1("early_not_busy", busy, 1'b0);
      chkw("early_word0", {64'h0, vec_o[31:0]}, {64'h0, 32'hA0});
      chkw("early_word5", {64'h0, vec_o[191:160]}, {64'h0, 32'hA5});
      chkw("early_word6_kept", {64'h0, vec_o[223:192]}, {64'h0, 32'h6});
      cyc();
      chk1("early_err_one_cycle", err_len, 1'b0);
      err_seen = 1'b0;
      for (int k = 0; k < 60; k++) begin
         send(32'h100 + WORD_W'(k), k == 59);
         err_seen |= err_len;
      end
      chk1("f2_no_err", err_seen, 1'b0);
      cyc(); cyc();
      chk1("f2_valid", res_valid, 1'b1);
      chkw("f2_res_data", res_data, {32'h102, 32'h101, 32'h101});
      res_ready = 1'b1; cyc(); res_ready = 1'b0;

      // Missing last: ld_last never set
      err_cnt = 0;
      for (int k = 0; k < 60; k++) begin
         send(WORD_W'(k * 3), 1'b0);
         if (k < 59 && err_len) err_cnt++;
      end
      chk1("miss_no_early_err", err_cnt == 0, 1'b1);
      chk1("miss_err_pulse", err_len, 1'b1);
      chk1("miss_busy", busy, 1'b1);
      cyc();
      chk1("miss_err_one_cycle", err_len, 1'b0);
      chk1("miss_valid_e1", res_valid, 1'b0);
      cyc();
      chk1("miss_valid_e2", res_valid, 1'b1);
      r1 = {32'd6, 32'd3, 32'd1};
      chkw("miss_res_data", res_data, r1);

`ifdef CLUSTER_VEC_SEQ_STEP_EN
      // Step with an inverting cluster: ~r1, then ~~r1
      inv = 1'b1; step_i = 1'b1; res_ready = 1'b1;
      cyc();
      step_i = 1'b0; res_ready = 1'b0;
      chk1("step1_valid_drop", res_valid, 1'b0);
      chk1("step1_busy", busy, 1'b1);
      chk1("step1_no_load", ld_ready, 1'b0);
      chkw("step1_feedback", vec_o[OUT_W-1:0], r1);
      cyc();
      chk1("step1_valid_e1", res_valid, 1'b0);
      cyc();
      chk1("step1_valid_e2", res_valid, 1'b1);
      chkw("step1_res_data", res_data, ~r1);
      step_i = 1'b1; res_ready = 1'b1;
      cyc();
      step_i = 1'b0; res_ready = 1'b0;
      cyc(); cyc();
      chk1("step2_valid", res_valid, 1'b1);
      chkw("step2_res_data", res_data, r1);
      inv = 1'b0;
`endif
      res_ready = 1'b1;
      cyc();
      res_ready = 1'b0;
      chk1("final_ld_ready", ld_ready, 1'b1);
      chk1("final_not_busy", busy, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
